// File: rtl/iob_eth_rx_pkg.sv
// ============================================================================
// iob_eth_rx_pkg : shared constants, FSM encoding and CRC-32 step function
// Revision: 1.0
// ============================================================================
`default_nettype none

package iob_eth_rx_pkg;

    localparam logic [3:0]  c_preamble_nibble = 4'h5;
    localparam logic [3:0]  c_sfd_nibble      = 4'hD;
    localparam logic [31:0] c_crc_residue     = 32'hC704DD7B;
    localparam logic [31:0] c_crc_poly        = 32'h04C11DB7;
    localparam logic [31:0] c_crc_init        = 32'hFFFFFFFF;
    localparam logic [47:0] c_bcast_mac       = 48'hFFFF_FFFF_FFFF;
    localparam int unsigned c_mac_bytes       = 6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_LO       = 3'd2,
        S_HI       = 3'd3,
        S_CHECK    = 3'd4,
        S_WAIT     = 3'd5,
        S_DISCARD  = 3'd6
    } state_t;

    // MSB-first register, byte bits consumed LSB first (wire order)
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ b[i]) c = {c[30:0], 1'b0} ^ c_crc_poly;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_eth_rx_crc.sv
// ============================================================================
// iob_eth_rx_crc : running Ethernet CRC-32 over stored bytes
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_eth_rx_crc
    import iob_eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_data_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (i_start)        crc_d = c_crc_init;
        else if (i_data_en) crc_d = crc32_byte(crc_q, i_data);
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= c_crc_init;
        else     crc_q <= crc_d;
    end

    assign o_crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/iob_eth_rx.sv
// ============================================================================
// iob_eth_rx : MII receive engine, writes frame bytes to RX buffer, checks FCS.
// Optional destination-MAC filter enabled by defining ETH_RX_MAC_FILTER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_eth_rx
    import iob_eth_rx_pkg::*;
#(
    parameter int          BUF_AW    = 11,
    parameter int          MIN_BYTES = 64,
    parameter logic [47:0] MAC_ADDR  = 48'h0
) (
    input  logic              RX_CLK,
    input  logic              rst,
    input  logic              RX_DV,
    input  logic [3:0]        RX_DATA,
    output logic              wr,
    output logic [BUF_AW-1:0] addr,
    output logic [7:0]        data,
    output logic              received,
    output logic [BUF_AW-1:0] nbytes,
    output logic              crc_err,
    input  logic              rcv_ack
);

    localparam logic [BUF_AW:0] c_max_count = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW:0] c_min_count = (BUF_AW+1)'(MIN_BYTES);
    localparam logic [BUF_AW:0] c_last_mac  = (BUF_AW+1)'(c_mac_bytes - 1);
`ifdef ETH_RX_MAC_FILTER_EN
    localparam logic            c_filter_en = 1'b1;
`else
    localparam logic            c_filter_en = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [3:0]        lo_q, lo_d;
    logic [BUF_AW:0]   count_q, count_d;
    logic              align_err_q, align_err_d;
    logic              ovf_q, ovf_d;
    logic [47:0]       mac_q, mac_d;
    logic              wr_q, wr_d;
    logic [BUF_AW-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              received_q, received_d;
    logic [BUF_AW-1:0] nbytes_q, nbytes_d;
    logic              crc_err_q, crc_err_d;

    logic [7:0]        w_byte;
    logic [47:0]       w_dest;
    logic              w_dest_match;
    logic              w_crc_start;
    logic              w_crc_en;
    logic [31:0]       w_crc;

    assign w_byte       = {RX_DATA, lo_q};
    assign w_dest       = {mac_q[39:0], w_byte};
    assign w_dest_match = (w_dest == MAC_ADDR) || (w_dest == c_bcast_mac);
    // Every IDLE cycle reloads the CRC so each frame starts clean
    assign w_crc_start  = (state_q == S_IDLE);

    iob_eth_rx_crc u_crc (
        .clk       (RX_CLK),
        .rst       (rst),
        .i_start   (w_crc_start),
        .i_data_en (w_crc_en),
        .i_data    (w_byte),
        .o_crc     (w_crc)
    );

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            count_q     <= '0;
            align_err_q <= 1'b0;
            ovf_q       <= 1'b0;
            mac_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            received_q  <= 1'b0;
            nbytes_q    <= '0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            count_q     <= count_d;
            align_err_q <= align_err_d;
            ovf_q       <= ovf_d;
            mac_q       <= mac_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            received_q  <= received_d;
            nbytes_q    <= nbytes_d;
            crc_err_q   <= crc_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (RX_DV) begin
                    if (received_q)                        state_d = S_DISCARD;
                    else if (RX_DATA == c_preamble_nibble) state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (!RX_DV)                            state_d = S_IDLE;
                else if (RX_DATA == c_sfd_nibble)      state_d = S_LO;
                else if (RX_DATA != c_preamble_nibble) state_d = S_IDLE;
            end
            S_LO:    state_d = RX_DV ? S_HI : S_CHECK;
            S_HI: begin
                if (!RX_DV)
                    state_d = S_CHECK;
                else if (c_filter_en && (count_q == c_last_mac) && !w_dest_match)
                    state_d = S_DISCARD;
                else
                    state_d = S_LO;
            end
            S_CHECK: state_d = (count_q < c_min_count) ? S_IDLE : S_WAIT;
            S_WAIT: begin
                // Ack wins over a frame starting in the same cycle
                if (rcv_ack)    state_d = S_IDLE;
                else if (RX_DV) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (!RX_DV) state_d = received_q ? S_WAIT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lo_d        = lo_q;
        count_d     = count_q;
        align_err_d = align_err_q;
        ovf_d       = ovf_q;
        mac_d       = mac_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        received_d  = received_q;
        nbytes_d    = nbytes_q;
        crc_err_d   = crc_err_q;
        w_crc_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d     = '0;
                align_err_d = 1'b0;
                ovf_d       = 1'b0;
            end
            S_LO: begin
                if (RX_DV) lo_d = RX_DATA;
            end
            S_HI: begin
                if (!RX_DV) begin
                    align_err_d = 1'b1;
                end else if (count_q == c_max_count) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_d     = 1'b1;
                    addr_d   = count_q[BUF_AW-1:0];
                    data_d   = w_byte;
                    w_crc_en = 1'b1;
                    count_d  = count_q + (BUF_AW+1)'(1);
                    if (count_q <= c_last_mac) mac_d = w_dest;
                end
            end
            S_CHECK: begin
                if (count_q < c_min_count) begin
                    addr_d = '0;
                end else begin
                    received_d = 1'b1;
                    nbytes_d   = count_q[BUF_AW-1:0] - BUF_AW'(4);
                    crc_err_d  = (w_crc != c_crc_residue) | align_err_q | ovf_q;
                end
            end
            S_WAIT: begin
                if (rcv_ack) begin
                    received_d = 1'b0;
                    addr_d     = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wr       = wr_q;
        addr     = addr_q;
        data     = data_q;
        received = received_q;
        nbytes   = nbytes_q;
        crc_err  = crc_err_q;
    end

endmodule

`default_nettype wire
